router_fifo: RTL
================

Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router; three instances, one per output port.
- Sits downstream of the synchronizer. It takes one bit of write_en plus the registered input byte, and returns full/empty to the synchronizer.
- Tracks packet boundaries via a stored header flag so the byte count of the packet being drained is known.
- The read side is driven by the destination's read_enb.

Parameters:
- DWIDTH, 8, data byte width.
- DEPTH, 16, number of entries (power of two).
- AW, 4, log2(DEPTH); pointers are AW+1 bits.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  synchronous, active-high reset (name kept for codebase consistency; asserted = 1).
- soft_reset  in  1  synchronous flush from the synchronizer timeout, active-high.
- write_enb  in  1  write request (one bit of synchronizer write_en).
- lfd_state  in  1  marks data_in as a header byte; same cycle as write_enb.
- data_in  in  DWIDTH  byte to store.
- read_enb  in  1  read request from the destination.
- data_out  out  DWIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- **Storage:** DEPTH x (DWIDTH+1). Bit DWIDTH holds lfd_state; bits [DWIDTH-1:0] hold data_in.
- **Pointers:** wr_ptr and rd_ptr are AW+1 bits and wrap modulo 2*DEPTH.
  - full when the MSBs differ and the low AW bits are equal.
  - empty when the pointers are equal.
  - full and empty are decoded combinationally from the registered pointers.
- **Reset and flush:** resetn = 1 at a clock edge sets wr_ptr = 0, rd_ptr = 0, pkt_cnt = 0, data_out = 0. Result: empty = 1, full = 0.
  - soft_reset = 1 (with resetn = 0) performs the identical flush.
  - Any read or write in the same cycle as resetn or soft_reset is discarded.
  - Memory contents are not cleared.
- **Write:** accepted iff write_enb && !full. Stores {lfd_state, data_in} at wr_ptr, then wr_ptr + 1.
  - A write while full is dropped silently; no pointer change.
- **Read:** accepted iff read_enb && !empty. Loads data_out with the stored byte at the next edge (1-cycle latency), then rd_ptr + 1.
  - A read while empty is ignored.
  - data_out holds its last value when no read is accepted.
- **Simultaneous read and write:**
  - Not full and not empty: both occur; occupancy unchanged.
  - full: read occurs, write is dropped (full is sampled before the edge).
  - empty: write occurs, read is ignored.
- **Packet counter:** pkt_cnt is 6 bits.
  - On an accepted read of a word with flag = 1 (header): pkt_cnt = data[7:2] + 1. This is the payload length plus the parity byte.
  - On an accepted read of a word with flag = 0 and pkt_cnt != 0: pkt_cnt - 1.
  - pkt_cnt never underflows.
  - When pkt_cnt reaches 0 and empty = 1, data_out is cleared to 0 on the following edge.
- **Header byte layout:** [1:0] destination address, [7:2] payload length (1..63). A length of 0 is loaded as 1 (parity only).

Decomposition:
- Shared package router_pkg holds:
  - DWIDTH and FIFO DEPTH constants.
  - Header field constants: ADDR_LSB = 0, ADDR_W = 2, LEN_LSB = 2, LEN_W = 6.
  - The 2-bit port address encodings 00/01/10.
- One sub-module, router_fifo_mem: a simple dual-port register array with a synchronous write port and an asynchronous read port, DEPTH x (DWIDTH+1).
- Pointer, flag and counter logic stay in router_fifo.

Test Plan:
- **Reset:** assert resetn for 2 cycles after random writes -> empty = 1, full = 0, data_out = 0x00; a subsequent read_enb is ignored.
- **Packet round-trip:**
  - Write header 0x0D (len 3, addr 01) with lfd_state = 1, then 0xA1, 0xA2, 0xA3 and parity 0x5F.
  - Read 5 times -> data_out sequence 0x0D, 0xA1, 0xA2, 0xA3, 0x5F, each 1 cycle after its read_enb.
  - Then data_out = 0x00 and empty = 1.
- **Fill to full:** 16 writes -> full = 1 after the 16th edge. A 17th write of 0xEE is dropped; 16 reads return the original bytes and never 0xEE.
- **Simultaneous at boundaries:**
  - At full, write_enb and read_enb together -> one byte out, full deasserts, the new byte is not stored.
  - At empty, both together -> the byte is stored, empty = 0, data_out unchanged.
- **Soft reset mid-packet:** 8 bytes written, 3 read, then soft_reset for 1 cycle -> empty = 1, data_out = 0x00, pkt_cnt = 0. The next header written and read is returned correctly.
- **Pointer wrap:** 40 interleaved write/read pairs with occupancy kept at 1..15 -> byte order preserved across the 2*DEPTH pointer wrap; full and empty never falsely assert.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath.
// Holds the byte width, the per-port FIFO geometry, the header field layout
// and the 2-bit destination port encodings.
package router_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  // Header byte: [1:0] destination address, [7:2] payload length.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;

  typedef enum logic [1:0] {
    PORT0 = 2'b00,
    PORT1 = 2'b01,
    PORT2 = 2'b10
  } port_addr_e;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array backing the router output FIFO.
// Ports:
//   clk_i    rising-edge clock for the write port
//   we_i     write strobe (already qualified by full/flush upstream)
//   waddr_i  write address
//   wdata_i  {header flag, data byte}
//   raddr_i  read address
//   rdata_o  asynchronous read data at raddr_i
module router_fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH:0]   wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH:0]   rdata_o
);

  logic [DWIDTH:0] mem_q [DEPTH];

  // Contents are intentionally never reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router.
// Stores {header flag, byte} words, decodes full/empty from AW+1 bit
// pointers and tracks the remaining byte count of the packet being drained.
// Ports:
//   clock       rising-edge clock
//   resetn      synchronous reset, active-high (asserted = 1)
//   soft_reset  synchronous flush from the synchronizer timeout
//   write_enb   write request
//   lfd_state   data_in is a header byte
//   data_in     byte to store
//   read_enb    read request from the destination
//   data_out    registered read data (1-cycle latency)
//   full        occupancy == DEPTH
//   empty       occupancy == 0
module router_fifo
  import router_pkg::*;
#(
  parameter int DWIDTH = DATA_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AW     = FIFO_AW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              read_enb,
  output logic [DWIDTH-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [DWIDTH-1:0]  data_out_q, data_out_d;
  logic [DWIDTH:0]    rd_word;
  logic               flush;
  logic               wr_acc;
  logic               rd_acc;

  // Header length plus the parity byte; a length of 63 would wrap the
  // 6-bit counter to zero, so it saturates at the largest count instead.
  function automatic logic [LEN_W-1:0] hdr_cnt(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + {{LEN_W{1'b0}}, 1'b1};
    if (sum[LEN_W]) begin
      return {LEN_W{1'b1}};
    end
    return sum[LEN_W-1:0];
  endfunction

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Reset and flush both swallow any same-cycle read or write.
  assign flush  = resetn | soft_reset;
  assign wr_acc = write_enb & ~full  & ~flush;
  assign rd_acc = read_enb  & ~empty & ~flush;

  router_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({lfd_state, data_in}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_word[DWIDTH-1:0];
        if (rd_word[DWIDTH]) begin
          pkt_cnt_d = hdr_cnt(rd_word[LEN_LSB +: LEN_W]);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end else if ((pkt_cnt_q == '0) && empty) begin
        // Packet fully drained and nothing left: return the output to idle.
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    pkt_cnt_q  <= pkt_cnt_d;
    data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;

endmodule
